// File: rtl/lc3_datapath_monitor.sv
// Runtime checker for the LC-3 datapath: bus-driver exclusivity, bus/driver agreement,
// NZP encoding/value and post-reset state, with sticky flags, saturating counts and first-error record.
module lc3_datapath_monitor #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned NUM_DRV     = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TS_W        = 16,
   parameter bit          HALT_ON_ERR = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mon_en,
   input  logic                     clr,
   input  logic [NUM_DRV-1:0]       drv_en,
   input  logic [NUM_DRV*WIDTH-1:0] drv_data,
   input  logic [WIDTH-1:0]         bus,
   input  logic                     flag_we,
   input  logic [2:0]               nzp,
   input  logic                     state_zero,
   output logic [4:0]               err_sticky,
   output logic                     err_any,
   output logic [5*CNT_W-1:0]       err_count,
   output logic                     first_vld,
   output logic [2:0]               first_id,
   output logic [TS_W-1:0]          first_ts,
   output logic                     halted
);
   localparam int unsigned NCHK = 5;

   typedef enum logic [1:0] {POST_RST, RUN, HALTED} state_t;

   state_t            state, state_nx;
   logic [NCHK-1:0]   fire;
   logic [2:0]        low_id;
   logic [2:0]        nzp_exp;
   logic              pend;
   logic              flags_init;
   logic [WIDTH-1:0]  bus_q;
   logic [TS_W-1:0]   ts;

   assign err_any = |err_sticky;

   always_comb begin
      nzp_exp = {bus_q[WIDTH-1], (bus_q == '0), (!bus_q[WIDTH-1] && (bus_q != '0))};
   end

   // Check evaluation and next-state
   always_comb begin
      state_nx = state;
      fire     = '0;
      unique case (state)
         POST_RST: begin
            fire[4]  = mon_en && !state_zero;
            state_nx = RUN;
         end
         RUN: begin
            if (mon_en) begin
               fire[0] = $countones(drv_en) > 1;
               for (int unsigned i = 0; i < NUM_DRV; i++) begin
                  if (drv_en[i] && (bus != drv_data[i*WIDTH +: WIDTH])) fire[1] = 1'b1;
               end
               fire[2] = ($countones(nzp) > 1) || ((nzp == 3'b000) && flags_init);
               fire[3] = pend && (nzp != nzp_exp);
            end
            if (HALT_ON_ERR && !clr && (fire != '0)) state_nx = HALTED;
         end
         HALTED: begin
            if (clr) state_nx = RUN;
         end
         default: state_nx = POST_RST;
      endcase
   end

   always_comb begin
      low_id = 3'd0;
      for (int k = NCHK - 1; k >= 0; k--) begin
         if (fire[k]) low_id = 3'(k);
      end
   end

   // State register and free-running timestamp
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= POST_RST;
         halted <= 1'b0;
         ts     <= '0;
      end else begin
         state  <= state_nx;
         halted <= (state_nx == HALTED);
         ts     <= ts + TS_W'(1);
      end
   end

   // NZP write pipeline: each flag write is checked against its own bus value one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         flags_init <= 1'b0;
         bus_q      <= '0;
      end else if (clr) begin
         pend       <= 1'b0;
         flags_init <= 1'b0;
      end else if ((state != HALTED) && mon_en && flag_we) begin
         pend       <= 1'b1;
         bus_q      <= bus;
         flags_init <= 1'b1;
      end else begin
         pend       <= 1'b0;
      end
   end

   // Error logs; clr drops any errors firing in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= '0;
         err_count  <= '0;
         first_vld  <= 1'b0;
         first_id   <= 3'd0;
         first_ts   <= '0;
      end else if (clr) begin
         err_sticky <= '0;
         err_count  <= '0;
         first_vld  <= 1'b0;
         first_id   <= 3'd0;
         first_ts   <= '0;
      end else if (fire != '0) begin
         err_sticky <= err_sticky | fire;
         for (int unsigned k = 0; k < NCHK; k++) begin
            if (fire[k] && (err_count[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
               err_count[k*CNT_W +: CNT_W] <= err_count[k*CNT_W +: CNT_W] + CNT_W'(1);
         end
         if (!first_vld) begin
            first_vld <= 1'b1;
            first_id  <= low_id;
            first_ts  <= ts;
         end
      end
   end
endmodule

// File: tb/tb_lc3_datapath_monitor.sv
// Randomised bench for lc3_datapath_monitor: two instances (free-running and halt-on-error)
// compared every cycle against a behavioural model, plus directed scenarios.
`timescale 1ns/1ps
module tb_lc3_datapath_monitor;
   localparam int unsigned W  = 16;
   localparam int unsigned ND = 4;
   localparam int unsigned CW = 2;
   localparam int unsigned TW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic mon_en, clr, flag_we, state_zero;
   logic [ND-1:0]   drv_en;
   logic [ND*W-1:0] drv_data;
   logic [W-1:0]    bus;
   logic [2:0]      nzp = 3'b010;

   logic [4:0]      a_sticky, b_sticky;
   logic            a_any, b_any, a_vld, b_vld, a_halt, b_halt;
   logic [5*CW-1:0] a_cnt, b_cnt;
   logic [2:0]      a_id, b_id;
   logic [TW-1:0]   a_ts, b_ts;

   always #5 clk = ~clk;

   lc3_datapath_monitor #(.WIDTH(W), .NUM_DRV(ND), .CNT_W(CW), .TS_W(TW), .HALT_ON_ERR(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .drv_en(drv_en), .drv_data(drv_data),
      .bus(bus), .flag_we(flag_we), .nzp(nzp), .state_zero(state_zero),
      .err_sticky(a_sticky), .err_any(a_any), .err_count(a_cnt), .first_vld(a_vld),
      .first_id(a_id), .first_ts(a_ts), .halted(a_halt));

   lc3_datapath_monitor #(.WIDTH(W), .NUM_DRV(ND), .CNT_W(CW), .TS_W(TW), .HALT_ON_ERR(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .drv_en(drv_en), .drv_data(drv_data),
      .bus(bus), .flag_we(flag_we), .nzp(nzp), .state_zero(state_zero),
      .err_sticky(b_sticky), .err_any(b_any), .err_count(b_cnt), .first_vld(b_vld),
      .first_id(b_id), .first_ts(b_ts), .halted(b_halt));

   int checks = 0;
   int errors = 0;

   // Reference model; phase 0 = just out of reset, 1 = running, 2 = halted
   int          m_phase [2];
   logic [4:0]  m_sticky[2];
   int          m_cnt   [2][5];
   logic        m_vld   [2];
   logic [2:0]  m_id    [2];
   logic [15:0] m_fts   [2];
   logic        m_pend  [2];
   logic [15:0] m_busq  [2];
   logic        m_finit [2];
   int          m_ts;

   logic        prev_we = 1'b0;
   logic [15:0] prev_bus = 16'h0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] sign3(input logic [15:0] v);
      return {v[15], (v == 16'd0), (!v[15] && (v != 16'd0))};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0; m_sticky[d] = '0; m_vld[d] = 0; m_id[d] = '0; m_fts[d] = '0;
         m_pend[d] = 0; m_busq[d] = '0; m_finit[d] = 0;
         for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
      end
      m_ts = 0;
   endtask

   task automatic model_step();
      logic [4:0] f;
      int nxt;
      for (int d = 0; d < 2; d++) begin
         f = '0;
         if (m_phase[d] == 0) begin
            f[4] = mon_en && !state_zero;
         end else if (m_phase[d] == 1 && mon_en) begin
            if ($countones(drv_en) >= 2) f[0] = 1'b1;
            for (int i = 0; i < ND; i++)
               if (drv_en[i] && (drv_data[i*W +: W] !== bus)) f[1] = 1'b1;
            if ($countones(nzp) >= 2 || (nzp == 3'b000 && m_finit[d])) f[2] = 1'b1;
            if (m_pend[d] && nzp !== sign3(m_busq[d])) f[3] = 1'b1;
         end
         nxt = (m_phase[d] == 0) ? 1 : m_phase[d];
         if (clr) begin
            nxt = 1;
            m_sticky[d] = '0; m_vld[d] = 0; m_id[d] = '0; m_fts[d] = '0;
            for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
            m_pend[d] = 0; m_finit[d] = 0;
         end else begin
            if (f != 0) begin
               m_sticky[d] = m_sticky[d] | f;
               for (int k = 0; k < 5; k++)
                  if (f[k] && m_cnt[d][k] < 3) m_cnt[d][k]++;
               if (!m_vld[d]) begin
                  m_vld[d] = 1; m_fts[d] = 16'(m_ts);
                  for (int k = 4; k >= 0; k--) if (f[k]) m_id[d] = 3'(k);
               end
               if (d == 1 && m_phase[d] == 1) nxt = 2;
            end
            if (m_phase[d] != 2 && mon_en && flag_we) begin
               m_pend[d] = 1; m_busq[d] = bus; m_finit[d] = 1;
            end else begin
               m_pend[d] = 0;
            end
         end
         m_phase[d] = nxt;
      end
      m_ts = (m_ts + 1) % 65536;
   endtask

   task automatic cmp_dut(input int d, input logic [4:0] st, input logic any, input logic [5*CW-1:0] cnt,
                          input logic vld, input logic [2:0] id, input logic [TW-1:0] ts, input logic hlt);
      logic [5*CW-1:0] ec;
      string p;
      p = (d == 0) ? "a_" : "b_";
      for (int k = 0; k < 5; k++) ec[k*CW +: CW] = CW'(m_cnt[d][k]);
      chk({p, "sticky"}, st, m_sticky[d]);
      chk({p, "any"}, any, |m_sticky[d]);
      chk({p, "count"}, cnt, ec);
      chk({p, "first_vld"}, vld, m_vld[d]);
      chk({p, "first_id"}, id, m_id[d]);
      chk({p, "first_ts"}, ts, m_fts[d]);
      chk({p, "halted"}, hlt, m_phase[d] == 2);
   endtask

   task automatic compare();
      cmp_dut(0, a_sticky, a_any, a_cnt, a_vld, a_id, a_ts, a_halt);
      cmp_dut(1, b_sticky, b_any, b_cnt, b_vld, b_id, b_ts, b_halt);
   endtask

   task automatic cycle();
      model_step();
      prev_we  = flag_we && mon_en && !clr;
      prev_bus = bus;
      @(posedge clk);
      #1;
      compare();
   endtask

   // Legal traffic: at most one driver, bus agrees, nzp follows the previous flag write
   task automatic drive_clean();
      int i;
      drv_data = {$urandom, $urandom};
      drv_en = '0; clr = 1'b0; mon_en = 1'b1; state_zero = 1'b1;
      if (prev_we) nzp = sign3(prev_bus);
      else if ($countones(nzp) != 1) nzp = 3'b010;
      bus = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
         i = $urandom_range(0, ND - 1);
         if ($urandom_range(0, 4) == 0) drv_data[i*W +: W] = 16'h0;
         drv_en[i] = 1'b1;
         bus = drv_data[i*W +: W];
      end
      flag_we = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_rand();
      drive_clean();
      if ($urandom_range(0, 9) == 0) drv_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus = bus ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) nzp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) mon_en = 1'b0;
      if ($urandom_range(0, 24) == 0) clr = 1'b1;
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock
   task automatic do_reset(input logic sz);
      rst_n = 1'b0;
      model_reset();
      drive_clean();
      flag_we = 1'b0; prev_we = 1'b0; state_zero = sz;
      #1;
      compare();
      @(posedge clk);
      #1;
      compare();
      rst_n = 1'b1;
   endtask

   task automatic clr_cycle();
      drive_clean();
      clr = 1'b1;
      cycle();
   endtask

   initial begin
      #2;
      // T1: clean run after reset
      do_reset(1'b1);
      cycle();
      for (int n = 0; n < 100; n++) begin drive_clean(); cycle(); end
      chk("t1_any_a", a_any, 0);
      chk("t1_any_b", b_any, 0);
      chk("t1_cnt_a", a_cnt, 0);
      chk("t1_halt_b", b_halt, 0);

      // T1b: state not zero in the post-reset cycle
      do_reset(1'b0);
      cycle();
      chk("t1b_sticky4", a_sticky[4], 1);
      chk("t1b_id", a_id, 4);
      chk("t1b_ts", a_ts, 0);

      // T2: two drivers at ts=10, then T4/T5 saturation and halt freeze
      do_reset(1'b1);
      cycle();
      for (int n = 1; n < 10; n++) begin drive_clean(); flag_we = 1'b0; cycle(); end
      for (int n = 0; n < 7; n++) begin
         drive_clean(); flag_we = 1'b0;
         drv_data[2*W +: W] = drv_data[0 +: W];
         drv_en = 4'b0101; bus = drv_data[0 +: W];
         cycle();
         if (n == 0) begin
            chk("t2_sticky0", a_sticky[0], 1);
            chk("t2_id", a_id, 0);
            chk("t2_ts", a_ts, 10);
            chk("t5_halt", b_halt, 1);
         end
      end
      chk("t4_sat", a_cnt[1:0], 3);
      chk("t5_frozen", b_cnt[1:0], 1);
      chk("t5_still_halt", b_halt, 1);

      // T4b/T5b: clr beats a new error and releases HALTED
      drive_clean(); drv_en = 4'b0101; clr = 1'b1;
      cycle();
      chk("t4b_sticky", a_sticky, 0);
      chk("t4b_cnt", a_cnt, 0);
      chk("t4b_vld", a_vld, 0);
      chk("t5b_halt", b_halt, 0);

      // T2b: single-driver mismatch
      drive_clean(); flag_we = 1'b0;
      drv_en = 4'b0100; drv_data[2*W +: W] = 16'h1234; bus = 16'h1235;
      cycle();
      chk("t2b_sticky", a_sticky, 5'b00010);
      chk("t2b_id", a_id, 1);
      clr_cycle();

      // T3: wrong NZP value one cycle after a negative write
      drive_clean(); drv_en = '0; flag_we = 1'b1; bus = 16'h8000;
      cycle();
      chk("t3_no_early", a_sticky, 0);
      drive_clean(); drv_en = '0; flag_we = 1'b0; nzp = 3'b001;
      cycle();
      chk("t3_sticky", a_sticky, 5'b01000);
      chk("t3_id", a_id, 3);
      clr_cycle();

      // T3b: zero write checks clean, then nzp=0 after init
      drive_clean(); drv_en = '0; flag_we = 1'b1; bus = 16'h0000;
      cycle();
      drive_clean(); flag_we = 1'b0;
      cycle();
      chk("t3b_clean", a_any, 0);
      drive_clean(); flag_we = 1'b0; nzp = 3'b000;
      cycle();
      chk("t3b_onehot", a_sticky, 5'b00100);
      clr_cycle();

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin drive_rand(); cycle(); end

      // T6: asynchronous reset with logs populated
      drive_clean(); drv_en = '1;
      cycle();
      chk("t6_pre_any", a_any, 1);
      do_reset(1'b1);
      chk("t6_any", a_any, 0);
      chk("t6_cnt", a_cnt, 0);
      cycle();
      for (int n = 0; n < 20; n++) begin drive_clean(); cycle(); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
